cs_stream_driver: RTL and testbench

- Hardware producer/consumer for the computational-system core (CS: X[7:0] in, Y[9:0] out).
- Reads N_PAT input samples from a synchronous input memory and drives them to X at one sample per clock.
- Tracks the 9-sample window warm-up and CS latency, and writes each valid Y into an output memory.
- Replaces the file-based stimulus/check flow for on-chip self-test runs.

---
 rtl/cs_pkg.sv | 15 +
 rtl/cs_valid_delay.sv | 36 +++
 rtl/cs_stream_driver.sv | 156 +++++++++++++++
 tb/tb_cs_stream_driver.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cs_pkg.sv
// Shared widths and FSM state type for the CS stream driver.
package cs_pkg;

    localparam int WIN_DEFAULT = 9;
    localparam int X_W         = 8;
    localparam int Y_W         = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } cs_drv_state_t;

endpackage

// File: rtl/cs_valid_delay.sv
// Shift line for the window-full flag; every stage is exposed so the caller
// can tap both the capture point and the write strobe.
module cs_valid_delay #(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flag,
    output logic [DEPTH-1:0] o_taps
);

    logic [DEPTH-1:0] r_line;

    generate
        if (DEPTH == 1) begin : g_one
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_line <= '0;
                end else begin
                    r_line <= i_flag;
                end
            end
        end else begin : g_many
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_line <= '0;
                end else begin
                    r_line <= {r_line[DEPTH-2:0], i_flag};
                end
            end
        end
    endgenerate

    assign o_taps = r_line;

endmodule

// File: rtl/cs_stream_driver.sv
// Streams N_PAT samples from the input memory into the CS core and stores
// every Y produced once the WIN-sample window has filled.
module cs_stream_driver
    import cs_pkg::*;
#(
    parameter int N_PAT  = 2000,
    parameter int WIN    = WIN_DEFAULT,
    parameter int CS_LAT = 1,
    parameter int AW     = 15
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           rd_en,
    output logic [AW-1:0]  rd_addr,
    input  logic [X_W-1:0] rd_data,
    output logic [X_W-1:0] x,
    output logic           x_valid,
    input  logic [Y_W-1:0] y,
    output logic           wr_en,
    output logic [AW-1:0]  wr_addr,
    output logic [Y_W-1:0] wr_data,
    output logic           busy,
    output logic           done,
    output cs_drv_state_t  dbg_state
);

    localparam logic [AW-1:0] LAST_RD   = AW'(N_PAT - 1);
    localparam logic [AW-1:0] LAST_WR   = AW'(N_PAT - WIN);
    localparam logic [AW-1:0] SMP_MAX   = AW'(N_PAT);
    localparam logic [AW-1:0] WIN_CNT   = AW'(WIN);
    localparam int            DLY_DEPTH = CS_LAT + 1;

    cs_drv_state_t        r_state;
    logic                 r_rd_en;
    logic [AW-1:0]        r_rd_addr;
    logic                 r_rd_vld;
    logic [X_W-1:0]       r_x;
    logic                 r_x_valid;
    logic [AW-1:0]        r_smp_cnt;
    logic [Y_W-1:0]       r_wr_data;
    logic [AW-1:0]        r_wr_addr;

    logic                 w_start_ok;
    logic                 w_win_full;
    logic                 w_capture;
    logic                 w_wr_en;
    logic                 w_last_wr;
    logic [DLY_DEPTH-1:0] w_taps;

    assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    // r_smp_cnt counts the sample currently on x, so >= WIN means index >= WIN-1.
    assign w_win_full = r_x_valid && (r_smp_cnt >= WIN_CNT);
    assign w_wr_en    = w_taps[CS_LAT];
    assign w_last_wr  = w_wr_en && (r_wr_addr == LAST_WR);

    cs_valid_delay #(
        .DEPTH (DLY_DEPTH)
    ) u_valid_delay (
        .clk    (clk),
        .reset  (reset),
        .i_flag (w_win_full),
        .o_taps (w_taps)
    );

    // Y is live CS_LAT cycles after its window closes; the write follows one cycle later.
    generate
        if (CS_LAT == 0) begin : g_cap_direct
            assign w_capture = w_win_full;
        end else begin : g_cap_tap
            assign w_capture = w_taps[CS_LAT-1];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rd_en   <= 1'b0;
            r_rd_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state   <= ST_READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                ST_READ: begin
                    if (r_rd_addr == LAST_RD) begin
                        r_rd_en <= 1'b0;
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + AW'(1);
                    end
                end
                ST_DRAIN: begin
                    if (w_last_wr) begin
                        r_state <= ST_DONE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_vld  <= 1'b0;
            r_x       <= '0;
            r_x_valid <= 1'b0;
            r_smp_cnt <= '0;
        end else begin
            r_rd_vld  <= r_rd_en;
            r_x_valid <= r_rd_vld;
            if (r_rd_vld) begin
                r_x <= rd_data;
            end
            if (w_start_ok) begin
                r_smp_cnt <= '0;
            end else if (r_rd_vld && (r_smp_cnt != SMP_MAX)) begin
                r_smp_cnt <= r_smp_cnt + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_data <= '0;
            r_wr_addr <= '0;
        end else begin
            if (w_capture) begin
                r_wr_data <= y;
            end
            if (w_start_ok) begin
                r_wr_addr <= '0;
            end else if (w_wr_en) begin
                r_wr_addr <= r_wr_addr + AW'(1);
            end
        end
    end

    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign x         = r_x;
    assign x_valid   = r_x_valid;
    assign wr_en     = w_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign busy      = (r_state == ST_READ) || (r_state == ST_DRAIN);
    assign done      = (r_state == ST_DONE);
    assign dbg_state = r_state;

endmodule

// File: tb/tb_cs_stream_driver.sv
// Three driver instances (basic, minimum-length, long-latency) each fed by a
// memory model and a stub CS core, checked against a cycle-schedule model.
module tb_cs_stream_driver;
    import cs_pkg::*;

    logic       clk = 1'b0;
    logic [2:0] rst_v = 3'b000;
    logic [2:0] start_v = 3'b000;
    logic       chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_val(int g, int i);
        case (g)
            0:       return 8'(i + 1);
            1:       return 8'(i * 29 + 200);
            default: return 8'(255 - i);
        endcase
    endfunction

    task automatic check(string name, int g, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d @%0t: got %0d, expected %0d", name, g, $time, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int N = (g == 1) ? 9 : 12;
        localparam int L = (g == 2) ? 3 : 1;
        localparam int W = 9;

        logic          rst;
        logic          st;
        logic          rd_en;
        logic [14:0]   rd_addr;
        logic [7:0]    rd_data = '0;
        logic [7:0]    x;
        logic          x_valid;
        logic [9:0]    y;
        logic          wr_en;
        logic [14:0]   wr_addr;
        logic [9:0]    wr_data;
        logic          busy;
        logic          done;
        cs_drv_state_t dbg_state;
        logic [9:0]    y_pipe [L];
        int            t = 0;
        int            wr_cnt = 0;

        assign rst = rst_v[g];
        assign st  = start_v[g];

        cs_stream_driver #(
            .N_PAT  (N),
            .WIN    (W),
            .CS_LAT (L),
            .AW     (15)
        ) u_dut (
            .clk       (clk),
            .reset     (rst),
            .start     (st),
            .rd_en     (rd_en),
            .rd_addr   (rd_addr),
            .rd_data   (rd_data),
            .x         (x),
            .x_valid   (x_valid),
            .y         (y),
            .wr_en     (wr_en),
            .wr_addr   (wr_addr),
            .wr_data   (wr_data),
            .busy      (busy),
            .done      (done),
            .dbg_state (dbg_state)
        );

        always @(posedge clk) begin
            if (rd_en) rd_data <= mem_val(g, int'(rd_addr));
        end

        always @(posedge clk) begin
            y_pipe[0] <= {2'b00, x} + 10'd100;
            for (int s = 1; s < L; s++) y_pipe[s] <= y_pipe[s-1];
        end
        assign y = y_pipe[L-1];

        always @(posedge clk) begin
            if (wr_en) wr_cnt <= wr_cnt + 1;
        end

        // t = cycle number within the current run; 0 means idle since reset.
        always @(posedge clk or posedge rst) begin
            if (rst) t <= 0;
            else if (st && (t == 0 || t >= N + 4 + L)) t <= 1;
            else if (t > 0 && t < 1000) t <= t + 1;
        end

        always @(negedge clk) begin
            if (chk_en) begin
                if (t == 0) begin
                    check("idle_rd_en", g, int'(rd_en), 0);
                    check("idle_rd_addr", g, int'(rd_addr), 0);
                    check("idle_x", g, int'(x), 0);
                    check("idle_x_valid", g, int'(x_valid), 0);
                    check("idle_wr_en", g, int'(wr_en), 0);
                    check("idle_wr_addr", g, int'(wr_addr), 0);
                    check("idle_wr_data", g, int'(wr_data), 0);
                    check("idle_busy", g, int'(busy), 0);
                    check("idle_done", g, int'(done), 0);
                    check("idle_state", g, int'(dbg_state), int'(ST_IDLE));
                end else begin
                    check("rd_en", g, int'(rd_en), int'(t >= 1 && t <= N));
                    if (t >= 1 && t <= N) check("rd_addr", g, int'(rd_addr), t - 1);
                    check("x_valid", g, int'(x_valid), int'(t >= 3 && t <= N + 2));
                    if (t >= 3 && t <= N + 2) check("x", g, int'(x), int'(mem_val(g, t - 3)));
                    if (t > N + 2) check("x_hold", g, int'(x), int'(mem_val(g, N - 1)));
                    check("wr_en", g, int'(wr_en), int'(t >= W + 3 + L && t <= N + 3 + L));
                    if (t >= W + 3 + L && t <= N + 3 + L) begin
                        check("wr_addr", g, int'(wr_addr), t - (W + 3 + L));
                        check("wr_data", g, int'(wr_data),
                              int'(mem_val(g, t - (W + 3 + L) + W - 1)) + 100);
                    end
                    check("busy", g, int'(busy), int'(t <= N + 3 + L));
                    check("done", g, int'(done), int'(t > N + 3 + L));
                    check("state", g, int'(dbg_state),
                          (t <= N) ? int'(ST_READ) : (t <= N + 3 + L) ? int'(ST_DRAIN) : int'(ST_DONE));
                end
            end
        end
    end

    // Hand-computed schedule points that pin the model above.
    always @(negedge clk) begin
        if (chk_en) begin
            case (g_inst[0].t)
                3:  check("lit_x_c3", 0, int'(g_inst[0].x), 1);
                12: check("lit_rd_addr_c12", 0, int'(g_inst[0].rd_addr), 11);
                13: check("lit_wr_data_c13", 0, int'(g_inst[0].wr_data), 109);
                14: check("lit_wr_data_c14", 0, int'(g_inst[0].wr_data), 110);
                15: check("lit_wr_data_c15", 0, int'(g_inst[0].wr_data), 111);
                16: begin
                    check("lit_wr_data_c16", 0, int'(g_inst[0].wr_data), 112);
                    check("lit_wr_addr_c16", 0, int'(g_inst[0].wr_addr), 3);
                end
                17: begin
                    check("lit_done_c17", 0, int'(g_inst[0].done), 1);
                    check("lit_busy_c17", 0, int'(g_inst[0].busy), 0);
                end
                default: ;
            endcase
            case (g_inst[1].t)
                12: check("lit_min_wr_en_c12", 1, int'(g_inst[1].wr_en), 0);
                13: begin
                    check("lit_min_wr_en_c13", 1, int'(g_inst[1].wr_en), 1);
                    check("lit_min_wr_addr_c13", 1, int'(g_inst[1].wr_addr), 0);
                    check("lit_min_wr_data_c13", 1, int'(g_inst[1].wr_data), 276);
                end
                14: check("lit_min_done_c14", 1, int'(g_inst[1].done), 1);
                default: ;
            endcase
            case (g_inst[2].t)
                14: check("lit_lat_wr_en_c14", 2, int'(g_inst[2].wr_en), 0);
                15: check("lit_lat_wr_data_c15", 2, int'(g_inst[2].wr_data), 347);
                18: check("lit_lat_wr_addr_c18", 2, int'(g_inst[2].wr_addr), 3);
                19: check("lit_lat_done_c19", 2, int'(g_inst[2].done), 1);
                default: ;
            endcase
        end
    end

    task automatic start_pulse(input logic [2:0] mask);
        start_v = mask;
        @(posedge clk);
        #1;
        start_v = 3'b000;
    endtask

    initial begin
        #2;
        rst_v  = 3'b111;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_v = 3'b000;
        @(posedge clk);
        #1;
        start_pulse(3'b111);
        repeat (4) @(posedge clk);
        #1;
        start_pulse(3'b001);
        repeat (12) @(posedge clk);
        #1;
        start_pulse(3'b001);
        repeat (7) @(posedge clk);
        #1;
        rst_v[0] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_v[0] = 1'b0;
        @(posedge clk);
        #1;
        start_pulse(3'b111);
        repeat (25) @(posedge clk);
        #1;
        rst_v   = 3'b010;
        start_v = 3'b010;
        @(posedge clk);
        #1;
        rst_v   = 3'b000;
        start_v = 3'b000;
        repeat (4) @(posedge clk);
        #1;
        check("total_writes", 0, g_inst[0].wr_cnt, 8);
        check("total_writes", 1, g_inst[1].wr_cnt, 2);
        check("total_writes", 2, g_inst[2].wr_cnt, 8);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
